// File: rtl/spi_sample_capture_pkg.sv
// Shared types and field widths for the SPI sample capture block.
package spi_sample_pkg;

   localparam int WORD_W = 16;
   localparam int FREQ_W = 14;
   localparam int AMPL_W = 8;

   localparam logic [1:0] TAG_FREQ = 2'b01;
   localparam logic [1:0] TAG_AMPL = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      ACTIVE,
      STUCK,
      SETTLE,
      SAMPLE1,
      SAMPLE2,
      DECODE
   } state_t;

endpackage

// File: rtl/spi_sample_capture_if.sv
// Bundle between the Arduino SPI receiver side and the tone generator side.
interface spi_sample_capture_if;
   import spi_sample_pkg::*;

   logic              input_SPI_CS_n;
   logic [WORD_W-1:0] inputWord;
   logic [FREQ_W-1:0] outputFrequency;
   logic [AMPL_W-1:0] outputAmplitude;
   logic              frequencyValid;
   logic              amplitudeValid;
   logic              frameError;
   logic              busy;

   modport master (
      output input_SPI_CS_n, inputWord,
      input  outputFrequency, outputAmplitude, frequencyValid, amplitudeValid,
             frameError, busy
   );

   modport slave (
      input  input_SPI_CS_n, inputWord,
      output outputFrequency, outputAmplitude, frequencyValid, amplitudeValid,
             frameError, busy
   );

endinterface

// File: rtl/spi_sample_capture_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous GPIO level with rise/fall pulses.
module sync_edge_detect #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RESET_VAL}};
         hist  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         hist  <= chain[STAGES-1];
      end
   end

   // Edges are taken only between the last sync stage and the history flop
   assign rise = chain[STAGES-1] & ~hist;
   assign fall = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/spi_sample_capture.sv
// Captures a settled SPI word after CS_n rises, double-samples it and decodes
// frequency/amplitude updates for the tone generator.
module spi_sample_capture
   import spi_sample_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 CLK_50Mhz,
   input  logic                 reset_n,
   spi_sample_capture_if.slave  bus
);

   localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] capture;
   logic              cs_rise;
   logic              cs_fall;

   sync_edge_detect #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_cs_sync (
      .clk      (CLK_50Mhz),
      .rst_n    (reset_n),
      .async_in (bus.input_SPI_CS_n),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   assign bus.busy = (state != IDLE);

   always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         cnt                 <= '0;
         capture             <= '0;
         bus.outputFrequency <= '0;
         bus.outputAmplitude <= '0;
         bus.frequencyValid  <= 1'b0;
         bus.amplitudeValid  <= 1'b0;
         bus.frameError      <= 1'b0;
      end else begin
         bus.frequencyValid <= 1'b0;
         bus.amplitudeValid <= 1'b0;
         bus.frameError     <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state <= ACTIVE;
                  cnt   <= '0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  bus.frameError <= 1'b1;
                  state          <= STUCK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STUCK: begin
               if (cs_rise) state <= IDLE;
            end
            SETTLE: begin
               // A new frame started before the old word was sampled
               if (cs_fall) begin
                  bus.frameError <= 1'b1;
                  state          <= ACTIVE;
                  cnt            <= '0;
               end else if (cnt == SETTLE_LAST) begin
                  state <= SAMPLE1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE1: begin
               capture <= bus.inputWord;
               state   <= SAMPLE2;
            end
            SAMPLE2: begin
               if (bus.inputWord != capture) begin
                  bus.frameError <= 1'b1;
                  state          <= IDLE;
               end else begin
                  state <= DECODE;
               end
            end
            DECODE: begin
               case (capture[WORD_W-1 -: 2])
                  TAG_FREQ: begin
                     bus.outputFrequency <= capture[FREQ_W-1:0];
                     bus.frequencyValid  <= 1'b1;
                  end
                  TAG_AMPL: begin
                     if (capture[WORD_W-3:AMPL_W] == '0) begin
                        bus.outputAmplitude <= capture[AMPL_W-1:0];
                        bus.amplitudeValid  <= 1'b1;
                     end else begin
                        bus.frameError <= 1'b1;
                     end
                  end
                  default: bus.frameError <= 1'b1;
               endcase
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
